// File: rtl/fwd_pkg.sv
// Shared constants, select encodings and history-entry type for the
// operand-forwarding network.
package fwd_pkg;

    localparam int REG_AW    = 5;
    localparam int SEL_RF    = 0;
    localparam int SEL_WB    = 1;
    localparam int SEL_HIST0 = 2;
    localparam int HIST_XLEN = 32;

    typedef struct packed {
        logic                 vld;
        logic [REG_AW-1:0]    addr;
        logic [HIST_XLEN-1:0] data;
    } hist_entry_t;

    function automatic int sel_w(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/fwd_lookup.sv
// One read slot: priority match of a source register against the live WB
// write and the writeback history, newest first.
module fwd_lookup
    import fwd_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int SELW  = 2
) (
    input  logic              en,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   rf_data,
    input  logic              hist_vld  [DEPTH],
    input  logic [REG_AW-1:0] hist_addr [DEPTH],
    input  logic [XLEN-1:0]   hist_data [DEPTH],
    output logic [XLEN-1:0]   data,
    output logic [SELW-1:0]   sel,
    output logic              hit
);

    logic found;

    always_comb begin
        data  = rf_data;
        sel   = SELW'(SEL_RF);
        found = 1'b0;
        if (en && rs != '0) begin
            if (wb_we && wb_addr == rs) begin
                data  = wb_data;
                sel   = SELW'(SEL_WB);
                found = 1'b1;
            end
            // Ascending scan with a found flag keeps the newest matching entry.
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (!found && hist_vld[k] && hist_addr[k] == rs) begin
                    data  = hist_data[k];
                    sel   = SELW'(k + SEL_HIST0);
                    found = 1'b1;
                end
            end
        end
    end

    assign hit = (sel != '0);

endmodule

// File: rtl/fwd_bypass_network.sv
// Operand-forwarding unit: writeback history shift register, per-slot
// lookups and a saturating forward-hit counter.
module fwd_bypass_network
    import fwd_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16,
    localparam int SELW   = sel_w(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      wb_valid,
    input  logic                      wb_kill,
    input  logic [REG_AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]           wb_data,
    input  logic [NUM_SRC*REG_AW-1:0] rs_addr,
    input  logic [NUM_SRC*XLEN-1:0]   rf_data,
    output logic [NUM_SRC*XLEN-1:0]   fwd_data,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic [NUM_SRC-1:0]        fwd_hit,
    output logic [CNT_W-1:0]          hit_count
);

    logic              wb_we;
    logic              hist_vld  [DEPTH];
    logic [REG_AW-1:0] hist_addr [DEPTH];
    logic [XLEN-1:0]   hist_data [DEPTH];

    assign wb_we = wb_valid & ~wb_kill;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) hist_vld[k] <= 1'b0;
        end else if (!stall) begin
            hist_vld[0] <= wb_we & (wb_addr != '0);
            for (int unsigned k = 1; k < DEPTH; k++) hist_vld[k] <= hist_vld[k-1];
        end
    end

    // Payload is qualified by vld only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!stall) begin
            hist_addr[0] <= wb_addr;
            hist_data[0] <= wb_data;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                hist_addr[k] <= hist_addr[k-1];
                hist_data[k] <= hist_data[k-1];
            end
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
        fwd_lookup #(
            .XLEN  (XLEN),
            .DEPTH (DEPTH),
            .SELW  (SELW)
        ) u_lookup (
            .en        (~reset),
            .wb_we     (wb_we),
            .wb_addr   (wb_addr),
            .wb_data   (wb_data),
            .rs        (rs_addr[i*REG_AW +: REG_AW]),
            .rf_data   (rf_data[i*XLEN +: XLEN]),
            .hist_vld  (hist_vld),
            .hist_addr (hist_addr),
            .hist_data (hist_data),
            .data      (fwd_data[i*XLEN +: XLEN]),
            .sel       (fwd_sel[i*SELW +: SELW]),
            .hit       (fwd_hit[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count <= '0;
        end else if (!stall && |fwd_hit && hit_count != '1) begin
            hit_count <= hit_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_bypass_network.sv
// Randomised and directed checks of fwd_bypass_network against a queue-style
// reference model; a second instance with a 4-bit counter checks saturation.
module tb_fwd_bypass_network;
    import fwd_pkg::*;

    localparam int XLEN    = 32;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 2;
    localparam int SELW    = sel_w(DEPTH);

    logic                      clk;
    logic                      reset, stall, wb_valid, wb_kill;
    logic [4:0]                wb_addr;
    logic [XLEN-1:0]           wb_data;
    logic [NUM_SRC*5-1:0]      rs_addr;
    logic [NUM_SRC*XLEN-1:0]   rf_data;
    logic [NUM_SRC*XLEN-1:0]   fwd_data, fwd_data4;
    logic [NUM_SRC*SELW-1:0]   fwd_sel, fwd_sel4;
    logic [NUM_SRC-1:0]        fwd_hit, fwd_hit4;
    logic [15:0]               hit_count;
    logic [3:0]                hit_count4;

    fwd_bypass_network #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .wb_valid(wb_valid), .wb_kill(wb_kill),
        .wb_addr(wb_addr), .wb_data(wb_data), .rs_addr(rs_addr), .rf_data(rf_data),
        .fwd_data(fwd_data), .fwd_sel(fwd_sel), .fwd_hit(fwd_hit), .hit_count(hit_count)
    );

    fwd_bypass_network #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .stall(stall), .wb_valid(wb_valid), .wb_kill(wb_kill),
        .wb_addr(wb_addr), .wb_data(wb_data), .rs_addr(rs_addr), .rf_data(rf_data),
        .fwd_data(fwd_data4), .fwd_sel(fwd_sel4), .fwd_hit(fwd_hit4), .hit_count(hit_count4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    hist_entry_t m_hist [DEPTH];
    int unsigned m_cnt  = 0;
    int unsigned m_cnt4 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Newest-first search: live WB, then history entries 0..DEPTH-1, else regfile.
    function automatic void ref_lookup(input logic [4:0] rs, input logic [31:0] rf,
                                       output int sel, output logic [31:0] data);
        sel  = 0;
        data = rf;
        if (reset || rs == 0) return;
        if (wb_valid && !wb_kill && wb_addr == rs) begin
            sel  = 1;
            data = wb_data;
            return;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (m_hist[k].vld && m_hist[k].addr == rs) begin
                sel  = k + 2;
                data = m_hist[k].data;
                return;
            end
        end
    endfunction

    task automatic cycle();
        logic [NUM_SRC*SELW-1:0] e_sel;
        logic [NUM_SRC*XLEN-1:0] e_data;
        logic [NUM_SRC-1:0]      e_hit;
        int                      s;
        logic [31:0]             d;
        @(negedge clk);
        for (int i = 0; i < NUM_SRC; i++) begin
            ref_lookup(rs_addr[i*5 +: 5], rf_data[i*XLEN +: XLEN], s, d);
            e_sel[i*SELW +: SELW] = SELW'(s);
            e_data[i*XLEN +: XLEN] = d;
            e_hit[i] = (s != 0);
        end
        check("fwd_sel",    64'(fwd_sel),    64'(e_sel));
        check("fwd_data",   64'(fwd_data),   64'(e_data));
        check("fwd_hit",    64'(fwd_hit),    64'(e_hit));
        check("hit_count",  64'(hit_count),  64'(m_cnt));
        check("fwd_sel4",   64'(fwd_sel4),   64'(e_sel));
        check("fwd_data4",  64'(fwd_data4),  64'(e_data));
        check("hit_count4", 64'(hit_count4), 64'(m_cnt4));
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) m_hist[k].vld = 1'b0;
            m_cnt  = 0;
            m_cnt4 = 0;
        end else if (!stall) begin
            if (e_hit != 0) begin
                if (m_cnt  < 65535) m_cnt++;
                if (m_cnt4 < 15)    m_cnt4++;
            end
            for (int k = DEPTH - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = '{vld: wb_valid && !wb_kill && wb_addr != 0, addr: wb_addr, data: wb_data};
        end
        #1;
    endtask

    task automatic set_in(input logic rst, input logic st, input logic v, input logic k,
                          input logic [4:0] wa, input logic [31:0] wd,
                          input logic [4:0] r0, input logic [4:0] r1);
        reset = rst; stall = st; wb_valid = v; wb_kill = k;
        wb_addr = wa; wb_data = wd;
        rs_addr = {r1, r0};
        rf_data = {$urandom, $urandom};
        #1;
    endtask

    logic [15:0] cnt_hold;

    initial begin
        for (int k = 0; k < DEPTH; k++) m_hist[k] = '0;
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        // Live WB match is suppressed while reset is high.
        set_in(1, 0, 1, 0, 5, 32'h1111_2222, 5, 5);
        check("rst_hit", 64'(fwd_hit), 64'd0);
        check("rst_data", 64'(fwd_data), 64'(rf_data));
        cycle();

        set_in(0, 0, 1, 0, 5, 32'hDEAD_BEEF, 5, 0);
        check("wb_sel", 64'(fwd_sel[SELW-1:0]), 64'd1);
        check("wb_data", 64'(fwd_data[31:0]), 64'hDEAD_BEEF);
        check("wb_hit", 64'(fwd_hit[0]), 64'd1);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 5, 0);
        check("h0_sel", 64'(fwd_sel[SELW-1:0]), 64'd2);
        check("h0_data", 64'(fwd_data[31:0]), 64'hDEAD_BEEF);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 5, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 5, 0);
        check("aged_sel", 64'(fwd_sel[SELW-1:0]), 64'd0);
        check("aged_data", 64'(fwd_data[31:0]), 64'(rf_data[31:0]));
        cycle();

        set_in(0, 0, 1, 0, 7, 32'd1, 0, 0); cycle();
        set_in(0, 0, 1, 0, 7, 32'd2, 0, 0); cycle();
        set_in(0, 0, 0, 0, 0, 0, 7, 7);
        check("waw_sel", 64'(fwd_sel[SELW-1:0]), 64'd2);
        check("waw_data", 64'(fwd_data[31:0]), 64'd2);
        check("waw_slot1", 64'(fwd_data[63:32]), 64'd2);
        cycle();

        set_in(0, 0, 1, 0, 0, 32'h1234, 0, 0);
        check("x0_hit", 64'(fwd_hit), 64'd0);
        check("x0_data", 64'(fwd_data), 64'(rf_data));
        cycle();
        set_in(0, 0, 1, 1, 3, 32'h3333, 3, 0);
        check("kill_live", 64'(fwd_hit[0]), 64'd0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 3, 3);
        check("kill_hist", 64'(fwd_hit), 64'd0);
        cycle();

        set_in(0, 0, 1, 0, 9,  32'hAA, 0, 0); cycle();
        set_in(0, 0, 1, 0, 10, 32'hBB, 0, 0); cycle();
        cnt_hold = hit_count;
        for (int n = 0; n < 3; n++) begin
            set_in(0, 1, 0, 0, 0, 0, 9, 10);
            check("stall_sel", 64'(fwd_sel), 64'({2'd2, 2'd3}));
            check("stall_data", 64'(fwd_data), {32'hBB, 32'hAA});
            cycle();
        end
        check("stall_cnt", 64'(hit_count), 64'(cnt_hold));
        set_in(1, 1, 0, 0, 0, 0, 9, 10);
        check("rst_stall_sel", 64'(fwd_sel), 64'd0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 9, 10);
        check("post_rst_sel", 64'(fwd_sel), 64'd0);
        check("post_rst_cnt", 64'(hit_count), 64'd0);
        cycle();

        for (int n = 0; n < 20; n++) begin
            set_in(0, 0, 1, 0, 11, $urandom, 11, 0);
            cycle();
        end
        check("sat4", 64'(hit_count4), 64'd15);
        check("cnt16", 64'(hit_count), 64'd20);
        set_in(0, 0, 1, 0, 11, 32'h5, 11, 0);
        cycle();
        check("sat4_hold", 64'(hit_count4), 64'd15);

        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20,
                   $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 15,
                   5'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
